// File: rtl/keyboard_pkg.sv
// Shared definitions for the PS/2 keyboard receive path.
// Frame FSM encoding and PS/2 framing constants.
package keyboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } kb_state_e;

    localparam int   PS2_DATA_BITS  = 8;
    localparam logic PS2_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/kb_fifo.sv
// First-word-fall-through scan-code FIFO.
// A push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
module kb_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             accepted
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop & ~empty;
    assign accepted = push & (~full | do_pop);
    assign head     = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accepted) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accepted) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/keyboard_rx_ctrl.sv
// PS/2 keyboard receiver in the system clock domain: sync, frame FSM,
// parity/stop checking, timeout abort, scan-code FIFO and sticky flags.
module keyboard_rx_ctrl
    import keyboard_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_keyboard_kb_clk,
    input  logic       io_keyboard_kb_data,
    input  logic       io_ctrl_rd,
    input  logic       io_ctrl_clr,
    output logic [7:0] io_ctrl_data,
    output logic       io_ctrl_valid,
    output logic       io_ctrl_interrupt,
    output logic       io_ctrl_overflow,
    output logic       io_ctrl_frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int BW = $clog2(PS2_DATA_BITS);

    kb_state_e state, state_nxt;

    logic          kc1, kc2, kc3;
    logic          kd1, kd2;
    logic          fall;
    logic [BW-1:0] bitcnt;
    logic [7:0]    shift;
    logic          par;
    logic [TW-1:0] tcnt;
    logic          timeout;
    logic          frame_ok;
    logic          push;
    logic          bad;
    logic          accepted;
    logic          fifo_full;
    logic          fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kc1 <= PS2_IDLE_LEVEL;
            kc2 <= PS2_IDLE_LEVEL;
            kc3 <= PS2_IDLE_LEVEL;
            kd1 <= PS2_IDLE_LEVEL;
            kd2 <= PS2_IDLE_LEVEL;
        end else begin
            kc1 <= io_keyboard_kb_clk;
            kc2 <= kc1;
            kc3 <= kc2;
            kd1 <= io_keyboard_kb_data;
            kd2 <= kd1;
        end
    end

    assign fall     = kc3 & ~kc2;
    // A falling edge in the same cycle keeps the frame alive.
    assign timeout  = (state != ST_IDLE) && !fall &&
                      (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign frame_ok = kd2 & (^shift ^ par);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = ST_IDLE;
        end else if (fall) begin
            unique case (state)
                ST_IDLE:   if (!kd2) state_nxt = ST_DATA;
                ST_DATA:   if (bitcnt == BW'(PS2_DATA_BITS - 1))
                               state_nxt = ST_PARITY;
                ST_PARITY: state_nxt = ST_STOP;
                ST_STOP:   state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        push = 1'b0;
        bad  = 1'b0;
        if (state == ST_STOP && fall) begin
            push = frame_ok;
            bad  = ~frame_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitcnt <= '0;
            shift  <= '0;
            par    <= 1'b0;
            tcnt   <= '0;
        end else begin
            if (state == ST_IDLE || fall) tcnt <= '0;
            else                          tcnt <= tcnt + TW'(1);
            if (fall) begin
                unique case (state)
                    ST_IDLE:   bitcnt <= '0;
                    ST_DATA: begin
                        shift  <= {kd2, shift[7:1]};
                        bitcnt <= bitcnt + BW'(1);
                    end
                    ST_PARITY: par <= kd2;
                    default:   ;
                endcase
            end
        end
    end

    kb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (io_ctrl_rd),
        .wdata    (shift),
        .head     (io_ctrl_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .accepted (accepted)
    );

    assign io_ctrl_valid = ~fifo_empty;

    // Set terms are checked after clr so a coincident event is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_ctrl_interrupt <= 1'b0;
            io_ctrl_overflow  <= 1'b0;
            io_ctrl_frame_err <= 1'b0;
        end else begin
            io_ctrl_interrupt <= accepted;
            if (io_ctrl_clr)         io_ctrl_overflow  <= 1'b0;
            if (push && !accepted)   io_ctrl_overflow  <= 1'b1;
            if (io_ctrl_clr)         io_ctrl_frame_err <= 1'b0;
            if (bad)                 io_ctrl_frame_err <= 1'b1;
        end
    end

    logic unused;
    assign unused = fifo_full;

endmodule

// File: tb/tb_keyboard_rx_ctrl.sv
// Directed bench for keyboard_rx_ctrl with a scaled PS/2 clock.
module tb_keyboard_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kb_clk = 1'b1;
    logic       kb_data = 1'b1;
    logic       rd = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       irq;
    logic       ovf;
    logic       ferr;

    int n_chk  = 0;
    int n_pass = 0;
    int irq_cnt = 0;
    int base;

    always #5 clk = ~clk;

    always @(posedge clk) if (irq) irq_cnt <= irq_cnt + 1;

    keyboard_rx_ctrl #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .io_keyboard_kb_clk  (kb_clk),
        .io_keyboard_kb_data (kb_data),
        .io_ctrl_rd          (rd),
        .io_ctrl_clr         (clr),
        .io_ctrl_data        (data),
        .io_ctrl_valid       (valid),
        .io_ctrl_interrupt   (irq),
        .io_ctrl_overflow    (ovf),
        .io_ctrl_frame_err   (ferr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // mode 1: check push latency, mode 2: rd high at the push edge
    task automatic send_bits(input logic [10:0] f, input int n,
                             input int mode);
        for (int i = 0; i < n; i++) begin
            tick(1);
            kb_data = f[i];
            tick(20);
            kb_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                tick(2);
                check("lat_early", {31'd0, valid}, 32'd0);
                tick(1);
                check("lat_irq", {31'd0, irq}, 32'd1);
                check("lat_valid", {31'd0, valid}, 32'd1);
                tick(1);
                check("irq_width", {31'd0, irq}, 32'd0);
                tick(36);
            end else if (i == 10 && mode == 2) begin
                tick(2);
                rd = 1'b1;
                tick(1);
                rd = 1'b0;
                check("rdpush_irq", {31'd0, irq}, 32'd1);
                tick(37);
            end else begin
                tick(40);
            end
            kb_clk = 1'b1;
            tick(19);
        end
        kb_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par,
                        input logic stop, input int mode);
        logic p;
        p = ~^b ^ bad_par;
        send_bits({stop, p, b, 1'b0}, 11, mode);
        tick(5);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        check(tag, {24'd0, data}, {24'd0, exp});
        check({tag, "_v"}, {31'd0, valid}, 32'd1);
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
    endtask

    initial begin
        tick(3);
        check("rst_data",  {24'd0, data}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_irq",   {31'd0, irq}, 32'd0);
        check("rst_ovf",   {31'd0, ovf}, 32'd0);
        check("rst_ferr",  {31'd0, ferr}, 32'd0);
        rst = 1'b0;
        tick(5);

        // single frame with exact latency
        base = irq_cnt;
        send(8'h1C, 1'b0, 1'b1, 1);
        check("f1_irqs", irq_cnt - base, 32'd1);
        check("f1_data", {24'd0, data}, 32'h1C);
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        check("f1_valid_after", {31'd0, valid}, 32'd0);
        check("f1_data_after", {24'd0, data}, 32'd0);

        // push with rd while empty keeps the byte
        send(8'h33, 1'b0, 1'b1, 2);
        pop_chk("empty_rdpush", 8'h33);
        check("empty_rdpush_gone", {31'd0, valid}, 32'd0);

        // two frames, no reads
        base = irq_cnt;
        send(8'hF0, 1'b0, 1'b1, 0);
        send(8'h1C, 1'b0, 1'b1, 0);
        check("two_irqs", irq_cnt - base, 32'd2);
        pop_chk("two_first", 8'hF0);
        pop_chk("two_second", 8'h1C);
        check("two_empty", {31'd0, valid}, 32'd0);

        // parity and stop errors
        base = irq_cnt;
        send(8'h1C, 1'b1, 1'b1, 0);
        check("par_ferr", {31'd0, ferr}, 32'd1);
        check("par_valid", {31'd0, valid}, 32'd0);
        pulse_clr();
        check("par_clr", {31'd0, ferr}, 32'd0);
        send(8'h1C, 1'b0, 1'b0, 0);
        check("stop_ferr", {31'd0, ferr}, 32'd1);
        check("stop_valid", {31'd0, valid}, 32'd0);
        check("err_irqs", irq_cnt - base, 32'd0);
        pulse_clr();
        check("stop_clr", {31'd0, ferr}, 32'd0);

        // overflow
        base = irq_cnt;
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, 1'b1, 0);
        check("ovf_flag", {31'd0, ovf}, 32'd1);
        check("ovf_irqs", irq_cnt - base, 32'd8);
        for (int i = 1; i <= 8; i++) pop_chk("ovf_rd", 8'(i));
        check("ovf_empty", {31'd0, valid}, 32'd0);
        pulse_clr();
        check("ovf_clr", {31'd0, ovf}, 32'd0);

        // full plus simultaneous pop at the push edge
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0, 1'b1, 0);
        send(8'h18, 1'b0, 1'b1, 2);
        check("fullpop_ovf", {31'd0, ovf}, 32'd0);
        for (int i = 1; i <= 8; i++) pop_chk("fullpop_rd", 8'h10 + 8'(i));
        check("fullpop_empty", {31'd0, valid}, 32'd0);

        // timeout abort of a partial frame
        base = irq_cnt;
        send_bits(11'b000_1010_0110, 5, 0);
        tick(250);
        send(8'h29, 1'b0, 1'b1, 0);
        check("to_irqs", irq_cnt - base, 32'd1);
        check("to_ferr", {31'd0, ferr}, 32'd0);
        pop_chk("to_data", 8'h29);
        check("to_empty", {31'd0, valid}, 32'd0);

        // reset mid-frame with bytes buffered
        send(8'hA1, 1'b0, 1'b1, 0);
        send(8'hA2, 1'b0, 1'b1, 0);
        send(8'hA3, 1'b1, 1'b1, 0);
        send(8'hA4, 1'b0, 1'b1, 0);
        send_bits(11'b000_0000_0010, 3, 0);
        rst = 1'b1;
        #1;
        check("mrst_data",  {24'd0, data}, 32'd0);
        check("mrst_valid", {31'd0, valid}, 32'd0);
        check("mrst_irq",   {31'd0, irq}, 32'd0);
        check("mrst_ovf",   {31'd0, ovf}, 32'd0);
        check("mrst_ferr",  {31'd0, ferr}, 32'd0);
        tick(3);
        rst = 1'b0;
        tick(5);
        base = irq_cnt;
        send(8'h5A, 1'b0, 1'b1, 0);
        check("post_irqs", irq_cnt - base, 32'd1);
        pop_chk("post_data", 8'h5A);
        check("post_empty", {31'd0, valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/keyboard_rx_ctrl.md
Name: keyboard_rx_ctrl

Overview:
PS/2 keyboard receive controller that replaces the free-running kb_clk-domain shifter with a single-clock design. It synchronizes kb_clk/kb_data into the system clock domain, sequences frame reception with an FSM, and checks start, parity and stop bits. Good scan codes are buffered in a small FIFO, which the CPU I/O path drains through a read-strobe handshake; an interrupt pulse is raised per accepted byte.

Parameters:
FIFO_DEPTH, 8, scan-code buffer entries; power of 2, ≥2
TIMEOUT_CYCLES, 50000, clk cycles without a kb_clk falling edge before an in-progress frame is aborted (1 ms at 50 MHz)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
io_keyboard_kb_clk  in  1  PS/2 clock pin, asynchronous
io_keyboard_kb_data  in  1  PS/2 data pin, asynchronous
io_ctrl_rd  in  1  pop strobe from CPU, one pop per high cycle
io_ctrl_clr  in  1  clears sticky error flags
io_ctrl_data  out  8  FIFO head, first-word-fall-through; 8'h00 when empty
io_ctrl_valid  out  1  FIFO non-empty
io_ctrl_interrupt  out  1  one-cycle pulse per accepted byte
io_ctrl_overflow  out  1  sticky: byte dropped because FIFO full
io_ctrl_frame_err  out  1  sticky: bad parity or stop bit

Behaviour:
- Reset (async, active-high): FSM IDLE, bit counter 0, shift register 0, timeout counter 0, FIFO empty, all outputs 0. Sync flops reset to 1 (idle bus level).
- kb_clk and kb_data each pass through 2 sync flops. A third flop on kb_clk gives fall = prev & ~cur. Data is sampled from the 2nd-stage data flop in the same cycle as fall.
- FSM acts only on cycles with fall, except for timeout:
  - IDLE: data=0 -> DATA, bitcnt=0; data=1 -> stay in IDLE (spurious edge).
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if stop=1 and (XOR of 8 data bits ^ parity)=1 (odd parity), push the byte; otherwise set frame_err and discard. Both cases -> IDLE.
- Timeout: in any non-IDLE state, the counter increments each clk and clears on fall. When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE and discards the partial frame; no flag is set. The counter is held at 0 in IDLE.
- Latency: the stop-bit falling edge at the pin is seen by the FSM at the 3rd rising clk edge after it. The push happens at that edge, so io_ctrl_valid and io_ctrl_interrupt are high in the following cycle.
- FIFO: rd/wr pointers have log2(FIFO_DEPTH)+1 bits, with wrap-around on the extra bit.
  - Full: a push without a simultaneous pop drops the new byte and sets overflow. No interrupt is raised; stored contents are unchanged.
  - Push and pop in the same cycle when full: both succeed and the count is unchanged.
  - Empty: rd is ignored; valid=0 and data=8'h00.
  - Push and pop in the same cycle when empty: the pushed byte stays and the pop is ignored.
- interrupt is high for exactly one cycle per accepted byte; it is never asserted for dropped or errored frames.
- clr clears overflow and frame_err. If a set event and clr occur in the same cycle, set wins.
- Reset mid-frame or with data buffered: everything is cleared immediately; the FIFO contents are lost.

Decomposition:
- Package keyboard_pkg: FSM state encoding (IDLE, DATA, PARITY, STOP), PS2_DATA_BITS=8, PS2_IDLE_LEVEL=1'b1.
- One sub-module, kb_fifo: a synchronous FWFT FIFO with push/pop/full/empty/head and the full-plus-simultaneous rule above. The FSM, sync, timeout and flags stay in the top module.

Test Plan:
- Frame 0x1C (start 0, bits 00111000 LSB first, parity 0, stop 1) at a 12.5 kHz kb_clk -> one interrupt pulse; valid=1, data=0x1C; after one rd cycle, valid=0 and data=0x00.
- Frame 0xF0 (parity 1), then 0x1C, with no reads -> data=0xF0, then 0x1C after the 1st rd; two interrupt pulses.
- 0x1C sent with parity 1, then 0x1C sent with stop 0 -> no push, no interrupt, frame_err=1; clr pulse -> frame_err=0.
- With FIFO_DEPTH=8, send 0x01..0x09 with no reads -> overflow=1 and 8 interrupts. Reads return 0x01..0x08. Then a frame arriving with rd high in the STOP-push cycle while full -> count stays 8 and the new byte is last.
- With TIMEOUT_CYCLES=200: start bit plus 4 data bits, then idle for 250 cycles, then a full 0x29 frame -> only 0x29 is buffered; frame_err=0.
- rst asserted mid-frame with 3 bytes buffered -> all outputs 0 immediately; a subsequent 0x5A frame is received correctly.
